// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core datapath: word width and the
// destination encoding used by the write-back / store demux.
package mips_pkg;

    localparam int   WORD_W  = 32;

    // Select-bit encoding: channel 0 feeds write-back, channel 1 feeds store.
    localparam logic CHAN_WB = 1'b0;
    localparam logic CHAN_ST = 1'b1;

endpackage

// File: rtl/demux_out_buffer.sv
// Per-destination circular FIFO. The push side is gated by the parent, and
// the pop side is valid/ready. It also counts the words it delivers.
// Storage is cleared on reset, so the head word reads zero until the
// first push.
module demux_out_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             valid,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // The wrap is explicit, so the design does not rely on DEPTH being a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The full check is redundant with the parent's gating. It stays as a local guard against overflow.
    assign do_push = push && !full;
    assign do_pop  = valid && ready;

    assign full  = (occ == OCC_W'(DEPTH));
    assign valid = (occ != '0);
    assign data  = mem[rd_ptr];
    assign count = count_q;

    // Storage, pointers, occupancy and delivered count.
    // A push and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr  <= next_ptr(rd_ptr);
                count_q <= count_q + CNT_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/demux_32bit_2outputs_buf.sv
// Routes one producer stream to the write-back or store consumer using a
// per-word select bit. Each consumer has its own buffer, so a stall on one
// side does not block traffic to the other.
module demux_32bit_2outputs_buf
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] out0_count,
    output logic [CNT_W-1:0] out1_count
);

    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    // Readiness depends only on the selected buffer, so a full buffer on one
    // side still lets words through to the other side.
    assign in_ready = (in_select == CHAN_ST) ? !full1 : !full0;
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_select == CHAN_WB);
    assign push1    = accept && (in_select == CHAN_ST);

    demux_out_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buf0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .full      (full0),
        .valid     (out0_valid),
        .ready     (out0_ready),
        .data      (out0_data),
        .count     (out0_count)
    );

    demux_out_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_buf1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .full      (full1),
        .valid     (out1_valid),
        .ready     (out1_ready),
        .data      (out1_data),
        .count     (out1_count)
    );

endmodule
